engine_load_rx: RTL and testbench

//  Per-engine receive side of the preprocess load path. The latency buffer broadcasts

---
 rtl/engine_load_rx.sv | 199 +++++++++++++++++++
 tb/tb_engine_load_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_load_rx.sv
// engine_load_rx: per-engine receive side of the preprocess load path.
// Captures this engine's clauses into a local clause queue and pointers into a
// local pointer table, tracks fill counts, and sequences IDLE -> LOADING ->
// READY -> RUN so the BCP engine knows when its data set is complete.
// Both stores have a registered read port that masks entries beyond the count.
module engine_load_rx #(
    parameter int CLQ_DEPTH = 64,
    parameter int PTR_DEPTH = 1024,
    parameter int CLAUSE_W  = 32,
    parameter int PTR_W     = 16,
    localparam int CQ_AW    = $clog2(CLQ_DEPTH),
    localparam int PT_AW    = $clog2(PTR_DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CLAUSE_W-1:0] clause_in,
    input  logic                clause_valid_in,
    input  logic [PTR_W-1:0]    ptr_in,
    input  logic                ptr_valid_in,
    input  logic                load_done_in,
    input  logic                engine_start_in,
    input  logic                clear_in,
    input  logic [CQ_AW-1:0]    cq_rd_idx,
    output logic [CLAUSE_W-1:0] cq_rd_data,
    input  logic [PT_AW-1:0]    pt_rd_idx,
    output logic [PTR_W-1:0]    pt_rd_data,
    output logic [CQ_AW:0]      clause_cnt,
    output logic [PT_AW:0]      ptr_cnt,
    output logic                load_ready_out,
    output logic                running_out,
    output logic                overflow_err,
    output logic                protocol_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [CQ_AW:0] CQ_FULL = (CQ_AW + 1)'(CLQ_DEPTH);
    localparam logic [PT_AW:0] PT_FULL = (PT_AW + 1)'(PTR_DEPTH);

    // Storage: plain arrays without reset so they map onto block RAM.
    logic [CLAUSE_W-1:0] cq_mem [CLQ_DEPTH];
    logic [PTR_W-1:0]    pt_mem [PTR_DEPTH];

    state_t             state_q, state_d;
    logic [CQ_AW:0]     cq_cnt_q, cq_cnt_d;
    logic [PT_AW:0]     pt_cnt_q, pt_cnt_d;
    logic               overflow_q, overflow_d;
    logic               protocol_q, protocol_d;
    logic               load_ready_q, load_ready_d;
    logic               running_q, running_d;
    logic [CLAUSE_W-1:0] cq_rd_q, cq_rd_d;
    logic [PTR_W-1:0]    pt_rd_q, pt_rd_d;
    logic               cq_we;
    logic               pt_we;
    logic               accept;

    // Next-state, write enables, counters and sticky error flags.
    always_comb begin
        state_d    = state_q;
        cq_cnt_d   = cq_cnt_q;
        pt_cnt_d   = pt_cnt_q;
        overflow_d = overflow_q;
        protocol_d = protocol_q;
        cq_we      = 1'b0;
        pt_we      = 1'b0;
        accept     = (state_q == ST_IDLE) || (state_q == ST_LOADING);

        if (clear_in) begin
            // Clear wins over everything: no write, no transition, errors wiped.
            state_d    = ST_IDLE;
            cq_cnt_d   = '0;
            pt_cnt_d   = '0;
            overflow_d = 1'b0;
            protocol_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_done_in) begin
                        state_d = ST_READY;
                    end else if (clause_valid_in || ptr_valid_in) begin
                        state_d = ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (load_done_in) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (engine_start_in) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Clause path: write at the current count, saturate at full.
            if (clause_valid_in) begin
                if (!accept) begin
                    protocol_d = 1'b1;
                end else if (cq_cnt_q == CQ_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    cq_we    = 1'b1;
                    cq_cnt_d = cq_cnt_q + (CQ_AW + 1)'(1);
                end
            end

            // Pointer path: independent of the clause path.
            if (ptr_valid_in) begin
                if (!accept) begin
                    protocol_d = 1'b1;
                end else if (pt_cnt_q == PT_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    pt_we    = 1'b1;
                    pt_cnt_d = pt_cnt_q + (PT_AW + 1)'(1);
                end
            end
        end

        // Status outputs are registered decodes of the next state so they
        // line up exactly with the state register.
        load_ready_d = (state_d == ST_READY);
        running_d    = (state_d == ST_RUN);
    end

    // Read data: entries at or beyond the count read as zero, so stale array
    // contents from an earlier load are never visible.
    always_comb begin
        cq_rd_d = '0;
        pt_rd_d = '0;
        if ({1'b0, cq_rd_idx} < cq_cnt_q) begin
            cq_rd_d = cq_mem[cq_rd_idx];
        end
        if ({1'b0, pt_rd_idx} < pt_cnt_q) begin
            pt_rd_d = pt_mem[pt_rd_idx];
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cq_cnt_q     <= '0;
            pt_cnt_q     <= '0;
            overflow_q   <= 1'b0;
            protocol_q   <= 1'b0;
            load_ready_q <= 1'b0;
            running_q    <= 1'b0;
            cq_rd_q      <= '0;
            pt_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            cq_cnt_q     <= cq_cnt_d;
            pt_cnt_q     <= pt_cnt_d;
            overflow_q   <= overflow_d;
            protocol_q   <= protocol_d;
            load_ready_q <= load_ready_d;
            running_q    <= running_d;
            cq_rd_q      <= cq_rd_d;
            pt_rd_q      <= pt_rd_d;
        end
    end

    // Clause queue write port; the index is below depth whenever cq_we is set.
    always_ff @(posedge clock) begin
        if (cq_we) begin
            cq_mem[cq_cnt_q[CQ_AW-1:0]] <= clause_in;
        end
    end

    // Pointer table write port.
    always_ff @(posedge clock) begin
        if (pt_we) begin
            pt_mem[pt_cnt_q[PT_AW-1:0]] <= ptr_in;
        end
    end

    assign cq_rd_data     = cq_rd_q;
    assign pt_rd_data     = pt_rd_q;
    assign clause_cnt     = cq_cnt_q;
    assign ptr_cnt        = pt_cnt_q;
    assign load_ready_out = load_ready_q;
    assign running_out    = running_q;
    assign overflow_err   = overflow_q;
    assign protocol_err   = protocol_q;

endmodule

// File: tb/tb_engine_load_rx.sv
// Testbench for engine_load_rx: directed stimulus pushes expected output values
// into a scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_engine_load_rx;

    localparam int CW    = 32;
    localparam int PW    = 16;
    localparam int CQ_AW = 6;
    localparam int PT_AW = 10;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [CW-1:0]     clause_in = '0;
    logic              clause_valid_in = 1'b0;
    logic [PW-1:0]     ptr_in = '0;
    logic              ptr_valid_in = 1'b0;
    logic              load_done_in = 1'b0;
    logic              engine_start_in = 1'b0;
    logic              clear_in = 1'b0;
    logic [CQ_AW-1:0]  cq_rd_idx = '0;
    logic [CW-1:0]     cq_rd_data;
    logic [PT_AW-1:0]  pt_rd_idx = '0;
    logic [PW-1:0]     pt_rd_data;
    logic [CQ_AW:0]    clause_cnt;
    logic [PT_AW:0]    ptr_cnt;
    logic              load_ready_out;
    logic              running_out;
    logic              overflow_err;
    logic              protocol_err;

    engine_load_rx #(
        .CLQ_DEPTH(64),
        .PTR_DEPTH(1024),
        .CLAUSE_W (CW),
        .PTR_W    (PW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clause_in      (clause_in),
        .clause_valid_in(clause_valid_in),
        .ptr_in         (ptr_in),
        .ptr_valid_in   (ptr_valid_in),
        .load_done_in   (load_done_in),
        .engine_start_in(engine_start_in),
        .clear_in       (clear_in),
        .cq_rd_idx      (cq_rd_idx),
        .cq_rd_data     (cq_rd_data),
        .pt_rd_idx      (pt_rd_idx),
        .pt_rd_data     (pt_rd_data),
        .clause_cnt     (clause_cnt),
        .ptr_cnt        (ptr_cnt),
        .load_ready_out (load_ready_out),
        .running_out    (running_out),
        .overflow_err   (overflow_err),
        .protocol_err   (protocol_err)
    );

    always #5 clock = ~clock;

    typedef enum int {
        S_CQ_CNT, S_PT_CNT, S_CQ_RD, S_PT_RD, S_READY, S_RUN, S_OVF, S_PROTO
    } sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(input sel_t s);
        case (s)
            S_CQ_CNT: return 32'(clause_cnt);
            S_PT_CNT: return 32'(ptr_cnt);
            S_CQ_RD:  return 32'(cq_rd_data);
            S_PT_RD:  return 32'(pt_rd_data);
            S_READY:  return 32'(load_ready_out);
            S_RUN:    return 32'(running_out);
            S_OVF:    return 32'(overflow_err);
            default:  return 32'(protocol_err);
        endcase
    endfunction

    task automatic exp_push(input sel_t s, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = s;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_all_zero(input string tag);
        exp_push(S_CQ_CNT, 0, {tag, "_cq_cnt"});
        exp_push(S_PT_CNT, 0, {tag, "_pt_cnt"});
        exp_push(S_CQ_RD,  0, {tag, "_cq_rd"});
        exp_push(S_PT_RD,  0, {tag, "_pt_rd"});
        exp_push(S_READY,  0, {tag, "_ready"});
        exp_push(S_RUN,    0, {tag, "_run"});
        exp_push(S_OVF,    0, {tag, "_ovf"});
        exp_push(S_PROTO,  0, {tag, "_proto"});
    endtask

    // Advance one clock; inputs change and expectations are queued 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every pending expectation on the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e.sel);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
                end else begin
                    $display("ok   %s: %0h", e.name, a);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        exp_all_zero("reset");
        tick();
        reset_n = 1'b1;

        // Test 1: three clauses, two pointers, load_done
        clause_in = 32'hA; clause_valid_in = 1'b1;
        tick();
        exp_push(S_CQ_CNT, 1, "t1_first_word");
        clause_in = 32'hB;
        tick();
        clause_in = 32'hC;
        tick();
        clause_valid_in = 1'b0;
        exp_push(S_CQ_CNT, 3, "t1_cq_cnt3");
        ptr_in = 16'h50; ptr_valid_in = 1'b1;
        tick();
        ptr_in = 16'h51;
        tick();
        ptr_valid_in = 1'b0;
        exp_push(S_PT_CNT, 2, "t1_pt_cnt2");
        load_done_in = 1'b1;
        tick();
        load_done_in = 1'b0;
        exp_push(S_READY,  1, "t1_ready");
        exp_push(S_RUN,    0, "t1_not_run");
        exp_push(S_CQ_CNT, 3, "t1_cq_cnt_ready");
        exp_push(S_PT_CNT, 2, "t1_pt_cnt_ready");
        cq_rd_idx = 6'd1; pt_rd_idx = 10'd1;
        tick();
        exp_push(S_CQ_RD, 32'hB,  "t1_rd_B");
        exp_push(S_PT_RD, 32'h51, "t1_rd_P1");

        // Test 4: valid in READY, start, load_done in RUN, clear
        clause_in = 32'hE; clause_valid_in = 1'b1;
        tick();
        clause_valid_in = 1'b0;
        exp_push(S_PROTO,  1, "t4_proto");
        exp_push(S_CQ_CNT, 3, "t4_cq_cnt_hold");
        exp_push(S_READY,  1, "t4_still_ready");
        engine_start_in = 1'b1;
        tick();
        engine_start_in = 1'b0;
        exp_push(S_RUN,   1, "t4_run");
        exp_push(S_READY, 0, "t4_ready_low");
        load_done_in = 1'b1;
        tick();
        load_done_in = 1'b0;
        exp_push(S_RUN, 1, "t4_done_in_run_ignored");
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        exp_push(S_RUN,    0, "t4_clr_run");
        exp_push(S_READY,  0, "t4_clr_ready");
        exp_push(S_CQ_CNT, 0, "t4_clr_cq");
        exp_push(S_PT_CNT, 0, "t4_clr_pt");
        exp_push(S_PROTO,  0, "t4_clr_proto");
        engine_start_in = 1'b1;
        tick();
        engine_start_in = 1'b0;
        exp_push(S_RUN, 0, "t4_start_in_idle_ignored");

        // Same-cycle read of the slot being written returns 0, then the new word
        cq_rd_idx = 6'd0;
        clause_in = 32'h77; clause_valid_in = 1'b1;
        tick();
        clause_valid_in = 1'b0;
        exp_push(S_CQ_RD,  0, "rw_same_cycle_old");
        exp_push(S_CQ_CNT, 1, "rw_cnt1");
        tick();
        exp_push(S_CQ_RD, 32'h77, "rw_next_cycle_new");

        // Test 2: first words arrive with load_done
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        clause_in = 32'hD; clause_valid_in = 1'b1;
        ptr_in = 16'h3C; ptr_valid_in = 1'b1;
        load_done_in = 1'b1;
        tick();
        clause_valid_in = 1'b0; ptr_valid_in = 1'b0; load_done_in = 1'b0;
        exp_push(S_CQ_CNT, 1, "t2_cq_cnt");
        exp_push(S_PT_CNT, 1, "t2_pt_cnt");
        exp_push(S_READY,  1, "t2_ready");
        cq_rd_idx = 6'd0; pt_rd_idx = 10'd0;
        tick();
        exp_push(S_CQ_RD, 32'hD,  "t2_rd_clause");
        exp_push(S_PT_RD, 32'h3C, "t2_rd_ptr");

        // Test 3: fill clause queue, then overflow
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        clause_valid_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            clause_in = 32'h1000 + 32'(i);
            tick();
        end
        exp_push(S_CQ_CNT, 64, "t3_full_cnt");
        exp_push(S_OVF,    0,  "t3_no_ovf_yet");
        clause_in = 32'hDEAD;
        tick();
        clause_valid_in = 1'b0;
        exp_push(S_CQ_CNT, 64, "t3_cnt_saturated");
        exp_push(S_OVF,    1,  "t3_ovf");
        cq_rd_idx = 6'd63;
        tick();
        exp_push(S_CQ_RD, 32'h103F, "t3_entry63");
        cq_rd_idx = 6'd0;
        tick();
        exp_push(S_CQ_RD, 32'h1000, "t3_entry0");

        // Test 5: asynchronous reset mid-load, then reload
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        clause_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clause_in = 32'h2000 + 32'(i);
            tick();
        end
        exp_push(S_CQ_RD, 32'h2000, "t5_pre_reset_rd");
        tick();
        reset_n = 1'b0;
        exp_all_zero("t5_async");
        tick();
        clause_valid_in = 1'b0;
        reset_n = 1'b1;
        clause_valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clause_in = 32'h3000 + 32'(i);
            tick();
        end
        clause_valid_in = 1'b0;
        exp_push(S_CQ_CNT, 4, "t5_reload_cnt");
        cq_rd_idx = 6'd5;
        tick();
        exp_push(S_CQ_RD, 0, "t5_idx5_zero");
        cq_rd_idx = 6'd3;
        tick();
        exp_push(S_CQ_RD, 32'h3003, "t5_idx3");

        // Test 6: load_done with no data; stale array contents stay hidden
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        load_done_in = 1'b1;
        tick();
        load_done_in = 1'b0;
        exp_push(S_READY,  1, "t6_ready");
        exp_push(S_CQ_CNT, 0, "t6_cq_cnt");
        exp_push(S_PT_CNT, 0, "t6_pt_cnt");
        cq_rd_idx = 6'd0; pt_rd_idx = 10'd0;
        tick();
        exp_push(S_CQ_RD, 0, "t6_cq_rd0");
        exp_push(S_PT_RD, 0, "t6_pt_rd0");

        tick();
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
